// File: rtl/vga_map_pkg.sv
// vga_map_pkg -- shared constants, opcodes and the sequencer state type for
// the 40x30 VGA character-map controller.
//
// Optional build macro: VGA_MAP_CTRL_FILL_EN. When it is defined, the FILL
// state exists.
package vga_map_pkg;

    localparam int MAP_COLS  = 40;
    localparam int MAP_ROWS  = 30;
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam int MAP_AW    = 12;
    localparam int MAP_DW    = 4;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_SHIFT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef VGA_MAP_CTRL_FILL_EN
        ST_FILL,
`endif
        ST_SHIFT,
        ST_FLUSH,
        ST_CLR
    } map_state_t;

    // row * cols built from shifted copies of row, one per set bit of the
    // constant cols. No multiplier is involved.
    function automatic logic [MAP_AW-1:0] row_base(input logic [4:0] row, input int cols);
        logic [MAP_AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < MAP_AW; i++) begin
            if (cols[i]) acc = acc + (MAP_AW'(row) << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_map_ctrl_if.sv
// vga_map_ctrl_if -- command channel between game logic and the map sequencer.
//   cmd_valid/cmd_ready : request / accept handshake
//   cmd_op              : OP_FILL or OP_SHIFT
//   cmd_row             : row to delete for SHIFT
//   cmd_data            : fill value / new row-0 value
//   busy, done          : engine active, one-cycle completion pulse
// Modports: master = game logic, slave = vga_map_ctrl.
interface vga_map_ctrl_if
    import vga_map_pkg::*;
#(
    parameter int DW = MAP_DW
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [4:0]    cmd_row;
    logic [DW-1:0] cmd_data;
    logic          busy;
    logic          done;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_data,
        input  cmd_ready, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_data,
        output cmd_ready, busy, done
    );
endinterface

// File: rtl/vga_map_addr_gen.sv
// vga_map_addr_gen -- running map address with row/column down-counters.
//   clk, rst             : clock, synchronous active-high reset
//   load                 : take load_addr / load_rows / up
//   step                 : advance one cell (address +/-1, column count down)
//   load_addr, load_rows : start address and number of rows to sweep
//   up                   : 1 = ascending addresses, 0 = descending
//   addr                 : current address
//   last                 : current cell is the final one of the sweep
module vga_map_addr_gen
    import vga_map_pkg::*;
#(
    parameter int COLS = MAP_COLS,
    parameter int AW   = MAP_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          up,
    input  logic          step,
    input  logic [AW-1:0] load_addr,
    input  logic [4:0]    load_rows,
    output logic [AW-1:0] addr,
    output logic          last
);
    localparam int CW = $clog2(COLS);

    logic [CW-1:0] col_cnt;
    logic [4:0]    row_cnt;
    logic          up_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            up_q    <= 1'b0;
        end else if (load) begin
            addr    <= load_addr;
            col_cnt <= CW'(COLS - 1);
            row_cnt <= load_rows;
            up_q    <= up;
        end else if (step) begin
            addr <= up_q ? addr + 1'b1 : addr - 1'b1;
            if (col_cnt == '0) begin
                col_cnt <= CW'(COLS - 1);
                row_cnt <= row_cnt - 1'b1;
            end else begin
                col_cnt <= col_cnt - 1'b1;
            end
        end
    end

    assign last = (row_cnt == 5'd1) && (col_cnt == '0);
endmodule

// File: rtl/vga_map_ctrl.sv
// vga_map_ctrl -- sequencer and port arbiter for the 40x30 character-map RAM.
// Shares the RAM read port between the renderer (always wins) and the engine,
// and the write port between host writes (IDLE only) and the engine.
// Commands: FILL (whole map) and SHIFT (delete a row, shift rows above down,
// clear row 0).
//   clk, rst                           : clock, synchronous active-high reset
//   cmd                                : command channel (slave modport)
//   host_wen/waddr/wdata, host_wready  : single-word host write
//   vga_ren/raddr, vga_rdata           : renderer read port
//   ram_wen/waddr/wdata, ram_ren/raddr : to map RAM
//   ram_rdata                          : from map RAM, 1-cycle latency
// Build macro VGA_MAP_CTRL_FILL_EN enables the FILL command; without it FILL
// is accepted and completes at once with no writes.
module vga_map_ctrl
    import vga_map_pkg::*;
#(
    parameter int COLS = MAP_COLS,
    parameter int ROWS = MAP_ROWS,
    parameter int AW   = MAP_AW,
    parameter int DW   = MAP_DW
) (
    input  logic          clk,
    input  logic          rst,
    vga_map_ctrl_if.slave cmd,
    input  logic          host_wen,
    input  logic [AW-1:0] host_waddr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_wready,
    input  logic          vga_ren,
    input  logic [AW-1:0] vga_raddr,
    output logic [DW-1:0] vga_rdata,
    output logic          ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata
);
    map_state_t    state;
    logic          busy_q, done_q;
    logic [DW-1:0] data_q;
    logic          pend_q;          // engine read issued last cycle
    logic [AW-1:0] pend_addr_q;     // destination of that read's data

    logic          gen_load, gen_up, gen_step, gen_last;
    logic [AW-1:0] gen_load_addr, gen_addr;
    logic [4:0]    gen_load_rows;
    logic          eng_rd;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    // The renderer takes the read port whenever it asks; the engine stalls.
    assign eng_rd = (state == ST_SHIFT) && !vga_ren;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gen_load      = 1'b0;
        gen_up        = 1'b1;
        gen_step      = 1'b0;
        gen_load_addr = '0;
        gen_load_rows = 5'd1;
        case (state)
            ST_IDLE: if (cmd.cmd_valid) begin
                if (cmd.cmd_op == OP_FILL) begin
                    gen_load      = 1'b1;
                    gen_load_rows = 5'(ROWS);
                end else if (cmd.cmd_row == '0) begin
                    gen_load      = 1'b1;
                end else begin
                    // Destination starts at the last cell of the deleted row.
                    gen_load      = 1'b1;
                    gen_up        = 1'b0;
                    gen_load_addr = AW'(row_base(cmd.cmd_row, COLS)) + AW'(COLS - 1);
                    gen_load_rows = cmd.cmd_row;
                end
            end
`ifdef VGA_MAP_CTRL_FILL_EN
            ST_FILL:  gen_step = 1'b1;
`endif
            ST_SHIFT: gen_step = eng_rd;
            ST_FLUSH: gen_load = 1'b1;      // rearm for the row-0 clear
            ST_CLR:   gen_step = 1'b1;
            default:  ;
        endcase
    end

    vga_map_addr_gen #(.COLS(COLS), .AW(AW)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (gen_load),
        .up        (gen_up),
        .step      (gen_step),
        .load_addr (gen_load_addr),
        .load_rows (gen_load_rows),
        .addr      (gen_addr),
        .last      (gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            pend_q <= 1'b0;
            case (state)
                ST_IDLE: if (cmd.cmd_valid) begin
                    data_q <= cmd.cmd_data;
                    if (cmd.cmd_op == OP_FILL) begin
`ifdef VGA_MAP_CTRL_FILL_EN
                        state  <= ST_FILL;
                        busy_q <= 1'b1;
`else
                        done_q <= 1'b1;
`endif
                    end else if (cmd.cmd_row >= 5'(ROWS)) begin
                        done_q <= 1'b1;     // nonexistent row: nothing to do
                    end else begin
                        state  <= (cmd.cmd_row == '0) ? ST_CLR : ST_SHIFT;
                        busy_q <= 1'b1;
                    end
                end
`ifdef VGA_MAP_CTRL_FILL_EN
                ST_FILL: if (gen_last) begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
`endif
                ST_SHIFT: begin
                    pend_q <= eng_rd;
                    if (eng_rd) pend_addr_q <= gen_addr;
                    if (eng_rd && gen_last) state <= ST_FLUSH;
                end
                ST_FLUSH: state <= ST_CLR;
                ST_CLR: if (gen_last) begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write port: host in IDLE, engine otherwise. A pending shift write always
    // lands the cycle after its read, whatever the renderer is doing.
    always_comb begin
        wen   = 1'b0;
        waddr = gen_addr;
        wdata = data_q;
        case (state)
            ST_IDLE: begin
                wen   = host_wen && (host_waddr < AW'(COLS * ROWS));
                waddr = host_waddr;
                wdata = host_wdata;
            end
`ifdef VGA_MAP_CTRL_FILL_EN
            ST_FILL:  wen = 1'b1;
`endif
            ST_CLR:   wen = 1'b1;
            ST_SHIFT, ST_FLUSH: begin
                wen   = pend_q;
                waddr = pend_addr_q;
                wdata = ram_rdata;
            end
            default:  ;
        endcase
    end

    assign ram_wen   = wen;
    assign ram_waddr = wen ? waddr : '0;
    assign ram_wdata = wen ? wdata : '0;

    // Engine reads the source cell one row above the destination.
    assign ram_ren   = vga_ren || eng_rd;
    assign ram_raddr = vga_ren ? vga_raddr : (eng_rd ? gen_addr - AW'(COLS) : '0);
    assign vga_rdata = ram_rdata;

    assign host_wready   = !busy_q;
    assign cmd.cmd_ready = !busy_q;
    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;
endmodule

// File: tb/tb_vga_map_ctrl.sv
// tb_vga_map_ctrl -- self-checking bench for vga_map_ctrl. Holds the map RAM
// and a behavioural map model; expected write order, read order and done
// timing are derived from the command rules, then checked every cycle.
`timescale 1ns/1ps
module tb_vga_map_ctrl;
    import vga_map_pkg::*;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int DEPTH = 1200;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_wen, host_wready;
    logic [11:0] host_waddr;
    logic [3:0]  host_wdata;
    logic        vga_ren;
    logic [11:0] vga_raddr;
    logic [3:0]  vga_rdata;
    logic        ram_wen, ram_ren;
    logic [11:0] ram_waddr, ram_raddr;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata = 4'h0;

    always #5 clk = ~clk;

    vga_map_ctrl_if #(.DW(4)) cif ();

    vga_map_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cif),
        .host_wen    (host_wen),
        .host_waddr  (host_waddr),
        .host_wdata  (host_wdata),
        .host_wready (host_wready),
        .vga_ren     (vga_ren),
        .vga_raddr   (vga_raddr),
        .vga_rdata   (vga_rdata),
        .ram_wen     (ram_wen),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_ren     (ram_ren),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata)
    );

    // Map RAM with registered read; also records what the renderer should see.
    logic [3:0] mem [0:4095] = '{default: 4'h0};
    logic [3:0] vga_exp = 4'h0;
    logic       vga_exp_vld = 1'b0;
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        vga_exp_vld <= vga_ren;
        if (vga_ren) vga_exp <= mem[vga_raddr];
    end

    logic [3:0] exp_map [0:DEPTH-1] = '{default: 4'h0};
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic host_write(input int addr, input logic [3:0] data);
        logic in_range;
        @(negedge clk);
        host_wen   = 1'b1;
        host_waddr = 12'(addr);
        host_wdata = data;
        #1;
        in_range = (addr < DEPTH);
        check("host_wready idle", 32'(host_wready), 32'd1);
        check("host ram_wen", 32'(ram_wen), 32'(in_range));
        if (in_range) begin
            check("host ram_waddr", 32'(ram_waddr), 32'(addr));
            check("host ram_wdata", 32'(ram_wdata), 32'(data));
            exp_map[addr] = data;
        end
        @(posedge clk);
        #1;
        host_wen = 1'b0;
    endtask

    task automatic preload_rows();
        for (int a = 0; a < DEPTH; a++) host_write(a, 4'((a / COLS) & 15));
    endtask

    task automatic compare_map(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== exp_map[a]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    // Map after deleting row r from the row-numbered preload, row 0 = nv.
    task automatic check_rows(input int r, input logic [3:0] nv, input string name);
        int bad;
        logic [3:0] want;
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (a / COLS == 0)      want = nv;
            else if (a / COLS <= r) want = 4'((a / COLS - 1) & 15);
            else                    want = 4'((a / COLS) & 15);
            if (mem[a] !== want) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    // Runs one command from acceptance (cycle 0) and checks every cycle.
    // stall_mode: 0 none, 1 vga_ren on odd cycles, 2 random. rst_at > 0
    // pulses reset in that cycle. done_at returns the cycle of done, or -1.
    task automatic run_cmd(input logic op, input logic [4:0] row, input logic [3:0] data,
                           input int stall_mode, input int rst_at, output int done_at);
        int         wq_a[$];
        logic [3:0] wq_d[$];
        int         rq[$];
        logic [3:0] snap [0:DEPTH-1];
        int         stalls, clr_start, done_k;
        bit         is_fill, is_shift, prev_rd, cur_rd, killed, exp_busy, eng_wr;

        snap     = exp_map;
        is_fill  = 1'b0;
`ifdef VGA_MAP_CTRL_FILL_EN
        is_fill  = (op == OP_FILL);
`endif
        is_shift = (op == OP_SHIFT) && (int'(row) < ROWS);
        if (is_fill)
            for (int a = 0; a < DEPTH; a++) begin wq_a.push_back(a); wq_d.push_back(data); end
        if (is_shift) begin
            for (int d = int'(row) * COLS + COLS - 1; d >= COLS; d--) begin
                wq_a.push_back(d);
                wq_d.push_back(snap[d - COLS]);
                rq.push_back(d - COLS);
            end
            for (int a = 0; a < COLS; a++) begin wq_a.push_back(a); wq_d.push_back(data); end
        end

        stalls    = 0;
        clr_start = 0;
        done_at   = -1;
        prev_rd   = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            cif.cmd_valid = (k == 0);
            cif.cmd_op    = op;
            cif.cmd_row   = row;
            cif.cmd_data  = data;
            case (stall_mode)
                1:       vga_ren = (k % 2 == 1);
                2:       vga_ren = ($urandom_range(0, 2) == 0);
                default: vga_ren = 1'b0;
            endcase
            vga_raddr = 12'($urandom_range(0, DEPTH - 1));
            rst       = (rst_at > 0) && (k == rst_at);
            killed    = (rst_at > 0) && (k > rst_at);

            if (!killed && k >= 1 && rq.size() > 0 && vga_ren) stalls++;
            if (is_fill) done_k = DEPTH + 1;
            else if (is_shift) begin
                clr_start = (row == 0) ? 1 : int'(row) * COLS + 2 + stalls;
                done_k    = clr_start + COLS;
            end else done_k = 1;

            host_wen   = !killed && k >= 1 && k < done_k && ($urandom_range(0, 3) == 0);
            host_waddr = 12'($urandom_range(0, DEPTH - 1));
            host_wdata = 4'($urandom);
            #1;

            exp_busy = !killed && k >= 1 && k < done_k;
            check("busy", 32'(cif.busy), 32'(exp_busy));
            check("cmd_ready", 32'(cif.cmd_ready), 32'(!exp_busy));
            check("host_wready", 32'(host_wready), 32'(!exp_busy));
            check("done", 32'(cif.done), 32'(!killed && k == done_k));
            if (cif.done && done_at < 0) done_at = k;

            cur_rd = 1'b0;
            if (vga_ren) begin
                check("ram_ren vga", 32'(ram_ren), 32'd1);
                check("ram_raddr vga", 32'(ram_raddr), 32'(vga_raddr));
            end else if (!killed && k >= 1 && rq.size() > 0) begin
                cur_rd = 1'b1;
                check("ram_ren eng", 32'(ram_ren), 32'd1);
                check("ram_raddr eng", 32'(ram_raddr), 32'(rq.pop_front()));
            end else begin
                check("ram_ren idle", 32'(ram_ren), 32'd0);
            end
            if (vga_exp_vld) check("vga_rdata", 32'(vga_rdata), 32'(vga_exp));

            eng_wr = !killed && k >= 1 &&
                     (prev_rd || (is_fill && k <= DEPTH) ||
                      (is_shift && k >= clr_start && k < clr_start + COLS));
            if (eng_wr) begin
                if (wq_a.size() == 0) check("write queue underrun", 32'd1, 32'd0);
                else begin
                    check("ram_wen eng", 32'(ram_wen), 32'd1);
                    check("ram_waddr eng", 32'(ram_waddr), 32'(wq_a[0]));
                    check("ram_wdata eng", 32'(ram_wdata), 32'(wq_d[0]));
                    exp_map[wq_a[0]] = wq_d[0];
                    void'(wq_a.pop_front());
                    void'(wq_d.pop_front());
                end
            end else begin
                check("ram_wen quiet", 32'(ram_wen), 32'd0);
            end
            prev_rd = cur_rd;

            if (rst_at == 0 && k == done_k) break;
            if (rst_at > 0 && k == rst_at + 3) break;
        end
        vga_ren  = 1'b0;
        host_wen = 1'b0;
        rst      = 1'b0;
        if (rst_at == 0) begin
            check("writes all issued", 32'(wq_a.size()), 32'd0);
            check("reads all issued", 32'(rq.size()), 32'd0);
        end
    endtask

    initial begin
        int d;
        int cnt;
        rst = 1'b1;
        cif.cmd_valid = 1'b0; cif.cmd_op = 1'b0; cif.cmd_row = '0; cif.cmd_data = '0;
        host_wen = 1'b0; host_waddr = '0; host_wdata = '0;
        vga_ren = 1'b0; vga_raddr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst cmd_ready", 32'(cif.cmd_ready), 32'd1);
        check("rst busy", 32'(cif.busy), 32'd0);
        check("rst done", 32'(cif.done), 32'd0);
        check("rst host_wready", 32'(host_wready), 32'd1);
        check("rst ram_wen", 32'(ram_wen), 32'd0);
        check("rst ram_ren", 32'(ram_ren), 32'd0);
        check("rst ram_waddr", 32'(ram_waddr), 32'd0);
        check("rst ram_raddr", 32'(ram_raddr), 32'd0);
        check("rst ram_wdata", 32'(ram_wdata), 32'd0);
        rst = 1'b0;

        host_write(100, 4'h7);
        host_write(1200, 4'h5);
        check("mem[100] after host write", 32'(mem[100]), 32'h7);
        compare_map("map after host writes");

        run_cmd(OP_FILL, 5'd0, 4'hA, 2, 0, d);
        cnt = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] == 4'hA) cnt++;
`ifdef VGA_MAP_CTRL_FILL_EN
        check("fill done cycle", 32'(d), 32'd1201);
        check("fill words 0xA", 32'(cnt), 32'd1200);
`else
        check("fill-disabled done cycle", 32'(d), 32'd1);
        check("fill-disabled words 0xA", 32'(cnt), 32'd0);
`endif
        compare_map("map after fill");

        preload_rows();
        run_cmd(OP_SHIFT, 5'd5, 4'h0, 0, 0, d);
        check("shift5 done cycle", 32'(d), 32'd242);
        check_rows(5, 4'h0, "shift5 rows");
        compare_map("map after shift5");

        preload_rows();
        run_cmd(OP_SHIFT, 5'd5, 4'h0, 1, 0, d);
        check("shift5 stalled done cycle", 32'(d), 32'd442);
        check_rows(5, 4'h0, "shift5 stalled rows");

        run_cmd(OP_SHIFT, 5'd0, 4'h3, 2, 0, d);
        check("shift0 done cycle", 32'(d), 32'd41);
        cnt = 0;
        for (int a = 0; a < COLS; a++) if (mem[a] == 4'h3) cnt++;
        check("shift0 row0 cleared", 32'(cnt), 32'd40);
        compare_map("map after shift0");

        run_cmd(OP_SHIFT, 5'd31, 4'h9, 0, 0, d);
        check("shift31 done cycle", 32'(d), 32'd1);
        run_cmd(OP_SHIFT, 5'd30, 4'h9, 0, 0, d);
        check("shift30 done cycle", 32'(d), 32'd1);
        compare_map("map after out-of-range shifts");

        for (int i = 0; i < 4; i++) begin
            run_cmd(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                    4'($urandom), 2, 0, d);
            compare_map("map after random command");
        end

`ifdef VGA_MAP_CTRL_FILL_EN
        run_cmd(OP_FILL, 5'd0, 4'h5, 0, 600, d);
`else
        run_cmd(OP_SHIFT, 5'd29, 4'h5, 0, 600, d);
`endif
        check("no done after reset", 32'(d), 32'hFFFF_FFFF);
        compare_map("map after mid-command reset");
        @(negedge clk); #1;
        check("cmd_ready after reset", 32'(cif.cmd_ready), 32'd1);
        host_write(200, 4'hC);
        compare_map("map after post-reset host write");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
